// File: rtl/noc_inverter_pe_pkg.sv
// Shared definitions for the inverter processing element.
// Packet field widths and offsets are macros so that other blocks can reuse them.
// A packet is laid out MSB first as {dest_x, dest_y, src_x, src_y, payload}.
// The package below turns these macros into typed localparams, the packet struct,
// the FSM state enum and small helper functions.
`ifndef NOC_INVERTER_PE_DEFS
`define NOC_INVERTER_PE_DEFS
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef X_SIZE
`define X_SIZE 4
`endif
`ifndef Y_SIZE
`define Y_SIZE 4
`endif
`define TOTAL_WIDTH (`DATA_WIDTH + 2*(`X_SIZE + `Y_SIZE))
`define PAYLOAD_LSB 0
`define SRC_Y_LSB   (`DATA_WIDTH)
`define SRC_X_LSB   (`DATA_WIDTH + `Y_SIZE)
`define DEST_Y_LSB  (`DATA_WIDTH + `Y_SIZE + `X_SIZE)
`define DEST_X_LSB  (`DATA_WIDTH + 2*`Y_SIZE + `X_SIZE)
`endif

package noc_inverter_pe_pkg;

   localparam int unsigned DATA_W  = `DATA_WIDTH;
   localparam int unsigned X_W     = `X_SIZE;
   localparam int unsigned Y_W     = `Y_SIZE;
   localparam int unsigned TOTAL_W = `TOTAL_WIDTH;
   localparam int unsigned CNT_W   = 16;

   // Packet payload as carried on the mesh links.
   typedef struct packed {
      logic [X_W-1:0]    dest_x;
      logic [Y_W-1:0]    dest_y;
      logic [X_W-1:0]    src_x;
      logic [Y_W-1:0]    src_y;
      logic [DATA_W-1:0] payload;
   } pkt_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_e;

   // Build the reply: route back to the sender, sign with our own coordinates.
   function automatic pkt_t make_resp(input pkt_t req,
                                      input logic [X_W-1:0] my_x,
                                      input logic [Y_W-1:0] my_y);
      pkt_t rsp;
      rsp.dest_x  = req.src_x;
      rsp.dest_y  = req.src_y;
      rsp.src_x   = my_x;
      rsp.src_y   = my_y;
      rsp.payload = ~req.payload;
      return rsp;
   endfunction

   // Saturating counter increment.
   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] val,
                                                input logic [1:0]       inc);
      logic [CNT_W:0] sum;
      sum = {1'b0, val} + (CNT_W + 1)'(inc);
      return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
   endfunction

endpackage

// File: rtl/pe_rx_fifo.sv
// Ingress FIFO of the inverter PE.
// Ports: clk, rst_n (async active-low); wr_en/wr_data push; rd_en pops the head;
//        rd_data_c shows the current head; full_c, empty_c, free_cnt_c report occupancy.
// A write on a full FIFO is accepted only when a pop happens on the same edge.
module pe_rx_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 48
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data_c,
   output logic                     full_c,
   output logic                     empty_c,
   output logic [$clog2(DEPTH):0]   free_cnt_c
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q,  count_d;
   logic             wr_ok_c, rd_ok_c;

   assign full_c     = (count_q == CW'(DEPTH));
   assign empty_c    = (count_q == '0);
   assign free_cnt_c = CW'(DEPTH) - count_q;
   assign rd_data_c  = mem_q[rd_ptr_q];

   assign rd_ok_c = rd_en & ~empty_c;
   assign wr_ok_c = wr_en & (~full_c | rd_ok_c);

   // Pointer and occupancy update; pointers wrap naturally at the power-of-two depth.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + CW'(wr_ok_c) - CW'(rd_ok_c);
      if (wr_ok_c) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_ok_c) rd_ptr_d = rd_ptr_q + AW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (wr_ok_c) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/noc_inverter_pe.sv
// Inverter processing element: answers each packet addressed to it with a reply
// whose payload is the bitwise inverse, sent back to the originator.
// Ports: clk, rst (async active-low, release synchronised internally);
//        i_data/i_valid ingress from the switch (no backpressure, o_ready is a hint);
//        o_data/o_valid/i_ready egress handshake; o_overflow sticky drop flag;
//        o_rx_cnt/o_tx_cnt/o_drop_cnt statistics.
// Build option: define PE_STATS_EN to include the statistics counters; otherwise
// the counter ports are tied to zero.
module noc_inverter_pe
   import noc_inverter_pe_pkg::*;
#(
   parameter int unsigned X_COORD    = 0,
   parameter int unsigned Y_COORD    = 0,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [TOTAL_W-1:0] i_data,
   input  logic               i_valid,
   output logic               o_ready,
   output logic [TOTAL_W-1:0] o_data,
   output logic               o_valid,
   input  logic               i_ready,
   output logic               o_overflow,
   output logic [CNT_W-1:0]   o_rx_cnt,
   output logic [CNT_W-1:0]   o_tx_cnt,
   output logic [CNT_W-1:0]   o_drop_cnt
);

   localparam int unsigned    FREE_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [X_W-1:0] MY_X   = X_W'(X_COORD);
   localparam logic [Y_W-1:0] MY_Y   = Y_W'(Y_COORD);

   // Reset: asserts immediately, releases two clock edges after rst rises.
   logic [1:0] rst_sync_q, rst_sync_d;
   logic       rst_n;

   assign rst_sync_d = {rst_sync_q[0], 1'b1};
   assign rst_n      = rst_sync_q[1];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rst_sync_q <= '0;
      else      rst_sync_q <= rst_sync_d;
   end

   // Ingress FIFO.
   pkt_t              head_c;
   logic              fifo_full_c, fifo_empty_c;
   logic [FREE_W-1:0] fifo_free_c;
   logic              wr_c, pop_c, ovf_c;

   // A full FIFO still takes the write if the head leaves on the same edge.
   assign wr_c  = i_valid & (~fifo_full_c | pop_c);
   assign ovf_c = i_valid & ~wr_c;

   pe_rx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (TOTAL_W)
   ) u_rx_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en      (wr_c),
      .wr_data    (i_data),
      .rd_en      (pop_c),
      .rd_data_c  (head_c),
      .full_c     (fifo_full_c),
      .empty_c    (fifo_empty_c),
      .free_cnt_c (fifo_free_c)
   );

   logic addr_hit_c, head_mine_c, head_foreign_c;

   assign addr_hit_c     = (head_c.dest_x == MY_X) && (head_c.dest_y == MY_Y);
   assign head_mine_c    = ~fifo_empty_c & addr_hit_c;
   assign head_foreign_c = ~fifo_empty_c & ~addr_hit_c;

   // Response FSM and output register.
   state_e            state_q, state_d;
   pkt_t              o_data_q, o_data_d;
   logic              o_valid_q, o_valid_d;
   logic              o_ready_q, o_ready_d;
   logic              o_overflow_q, o_overflow_d;
   logic [FREE_W-1:0] free_next_c;

   always_comb begin
      state_d   = state_q;
      o_data_d  = o_data_q;
      o_valid_d = o_valid_q;
      pop_c     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (head_mine_c) begin
               pop_c     = 1'b1;
               o_data_d  = make_resp(head_c, MY_X, MY_Y);
               o_valid_d = 1'b1;
               state_d   = ST_SEND;
            end else if (head_foreign_c) begin
               pop_c = 1'b1;
            end
         end
         ST_SEND: begin
            // Output is frozen until the switch takes it.
            if (o_valid_q && i_ready) begin
               if (head_mine_c) begin
                  pop_c    = 1'b1;
                  o_data_d = make_resp(head_c, MY_X, MY_Y);
               end else begin
                  o_valid_d = 1'b0;
                  state_d   = ST_IDLE;
                  if (head_foreign_c) pop_c = 1'b1;
               end
            end
         end
         default: begin
            o_valid_d = 1'b0;
            state_d   = ST_IDLE;
         end
      endcase
   end

   // Ready hint reflects the occupancy after this edge's push and pop.
   assign free_next_c  = fifo_free_c + FREE_W'(pop_c & ~fifo_empty_c) - FREE_W'(wr_c);
   assign o_ready_d    = (free_next_c >= FREE_W'(2));
   assign o_overflow_d = o_overflow_q | ovf_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         o_data_q     <= '0;
         o_valid_q    <= 1'b0;
         o_ready_q    <= 1'b1;
         o_overflow_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         o_data_q     <= o_data_d;
         o_valid_q    <= o_valid_d;
         o_ready_q    <= o_ready_d;
         o_overflow_q <= o_overflow_d;
      end
   end

   assign o_data     = o_data_q;
   assign o_valid    = o_valid_q;
   assign o_ready    = o_ready_q;
   assign o_overflow = o_overflow_q;

`ifdef PE_STATS_EN
   // Statistics counters, saturating.
   logic             tx_c, mis_c;
   logic [1:0]       drop_inc_c;
   logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
   logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
   logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

   assign tx_c       = o_valid_q & i_ready;
   assign mis_c      = pop_c & head_foreign_c;
   assign drop_inc_c = {1'b0, ovf_c} + {1'b0, mis_c};

   always_comb begin
      rx_cnt_d   = sat_add(rx_cnt_q, {1'b0, wr_c});
      tx_cnt_d   = sat_add(tx_cnt_q, {1'b0, tx_c});
      drop_cnt_d = sat_add(drop_cnt_q, drop_inc_c);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_cnt_q   <= '0;
         tx_cnt_q   <= '0;
         drop_cnt_q <= '0;
      end else begin
         rx_cnt_q   <= rx_cnt_d;
         tx_cnt_q   <= tx_cnt_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign o_rx_cnt   = rx_cnt_q;
   assign o_tx_cnt   = tx_cnt_q;
   assign o_drop_cnt = drop_cnt_q;
`else
   assign o_rx_cnt   = '0;
   assign o_tx_cnt   = '0;
   assign o_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_noc_inverter_pe.sv
// Directed bench for noc_inverter_pe at X=1, Y=2, 32-bit payload, 4-bit coordinates,
// FIFO depth 4. Counter expectations collapse to zero when PE_STATS_EN is undefined.
module tb_noc_inverter_pe;
   import noc_inverter_pe_pkg::*;

   localparam int unsigned W = TOTAL_W;
`ifdef PE_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] i_data;
   logic         i_valid;
   logic         o_ready;
   logic [W-1:0] o_data;
   logic         o_valid;
   logic         i_ready;
   logic         o_overflow;
   logic [15:0]  o_rx_cnt, o_tx_cnt, o_drop_cnt;

   int n_vec = 0;
   int n_err = 0;

   noc_inverter_pe #(
      .X_COORD    (1),
      .Y_COORD    (2),
      .FIFO_DEPTH (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .i_data     (i_data),
      .i_valid    (i_valid),
      .o_ready    (o_ready),
      .o_data     (o_data),
      .o_valid    (o_valid),
      .i_ready    (i_ready),
      .o_overflow (o_overflow),
      .o_rx_cnt   (o_rx_cnt),
      .o_tx_cnt   (o_tx_cnt),
      .o_drop_cnt (o_drop_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] pkt(input int dx, input int dy, input int sx,
                                        input int sy, input logic [31:0] pl);
      return {4'(dx), 4'(dy), 4'(sx), 4'(sy), pl};
   endfunction

   function automatic logic [15:0] exp_cnt(input int v);
      return STATS ? 16'(v) : 16'd0;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      i_valid = 1'b0;
      i_ready = 1'b0;
      i_data  = '0;
      rst     = 1'b0;
      repeat (3) tick;
      rst = 1'b1;
      repeat (4) tick;
   endtask

   task automatic test_reset;
      tick;
      rst = 1'b0;
      #1;
      n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL reset_o_valid: got %b want 0", o_valid); end
      n_vec++; if (o_data !== '0) begin n_err++; $display("FAIL reset_o_data: got %h want 0", o_data); end
      n_vec++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL reset_o_ready: got %b want 1", o_ready); end
      n_vec++; if (o_overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b want 0", o_overflow); end
      n_vec++; if ({o_rx_cnt, o_tx_cnt, o_drop_cnt} !== 48'd0) begin n_err++;
         $display("FAIL reset_counters: got %h %h %h want 0", o_rx_cnt, o_tx_cnt, o_drop_cnt); end
      repeat (2) tick;
      rst = 1'b1;
      repeat (4) tick;
   endtask

   task automatic test_single;
      logic [W-1:0] exp;
      do_reset;
      exp     = pkt(3, 0, 1, 2, 32'hFFFF0000);
      i_ready = 1'b1;
      i_data  = pkt(1, 2, 3, 0, 32'h0000FFFF);
      i_valid = 1'b1;
      tick;
      i_valid = 1'b0;
      n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL single_early: got o_valid %b want 0", o_valid); end
      tick;
      n_vec++; if ({o_valid, o_data} !== {1'b1, exp}) begin n_err++;
         $display("FAIL single_resp: got v=%b d=%h want v=1 d=%h", o_valid, o_data, exp); end
      tick;
      n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL single_pulse: got o_valid %b want 0", o_valid); end
      n_vec++; if (o_tx_cnt !== exp_cnt(1)) begin n_err++; $display("FAIL single_tx_cnt: got %0d want %0d", o_tx_cnt, exp_cnt(1)); end
      n_vec++; if (o_rx_cnt !== exp_cnt(1)) begin n_err++; $display("FAIL single_rx_cnt: got %0d want %0d", o_rx_cnt, exp_cnt(1)); end
   endtask

   task automatic test_backpressure;
      logic [W-1:0] ra, rb, rc;
      do_reset;
      ra = pkt(5, 6, 1, 2, 32'hEDCBA987);
      rb = pkt(7, 1, 1, 2, 32'h5A5AF0F0);
      rc = pkt(0, 3, 1, 2, 32'hFFFFFFFE);
      i_ready = 1'b0;
      i_valid = 1'b1;
      i_data  = pkt(1, 2, 5, 6, 32'h12345678); tick;
      i_data  = pkt(1, 2, 7, 1, 32'hA5A50F0F); tick;
      i_data  = pkt(1, 2, 0, 3, 32'h00000001); tick;
      i_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         n_vec++; if ({o_valid, o_data} !== {1'b1, ra}) begin n_err++;
            $display("FAIL bp_hold_%0d: got v=%b d=%h want v=1 d=%h", i, o_valid, o_data, ra); end
         tick;
      end
      i_ready = 1'b1;
      tick;
      n_vec++; if ({o_valid, o_data} !== {1'b1, rb}) begin n_err++;
         $display("FAIL bp_second: got v=%b d=%h want v=1 d=%h", o_valid, o_data, rb); end
      tick;
      n_vec++; if ({o_valid, o_data} !== {1'b1, rc}) begin n_err++;
         $display("FAIL bp_third: got v=%b d=%h want v=1 d=%h", o_valid, o_data, rc); end
      tick;
      n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL bp_done: got o_valid %b want 0", o_valid); end
      n_vec++; if (o_tx_cnt !== exp_cnt(3)) begin n_err++; $display("FAIL bp_tx_cnt: got %0d want %0d", o_tx_cnt, exp_cnt(3)); end
      n_vec++; if (o_rx_cnt !== exp_cnt(3)) begin n_err++; $display("FAIL bp_rx_cnt: got %0d want %0d", o_rx_cnt, exp_cnt(3)); end
   endtask

   task automatic test_overflow;
      logic [W-1:0] req [7];
      logic [W-1:0] rsp [7];
      for (int k = 0; k < 7; k++) begin
         req[k] = pkt(1, 2, k + 8, 15 - k, 32'hC0DE0000 + 32'(k));
         rsp[k] = pkt(k + 8, 15 - k, 1, 2, ~(32'hC0DE0000 + 32'(k)));
      end
      do_reset;
      i_ready = 1'b0;
      for (int k = 0; k < 6; k++) begin
         i_data  = req[k];
         i_valid = 1'b1;
         tick;
         if (k == 0) begin
            n_vec++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL ovf_ready_first: got %b want 1", o_ready); end
         end
         if (k == 4) begin
            n_vec++; if (o_ready !== 1'b0) begin n_err++; $display("FAIL ovf_ready_full: got %b want 0", o_ready); end
            n_vec++; if (o_overflow !== 1'b0) begin n_err++; $display("FAIL ovf_flag_early: got %b want 0", o_overflow); end
         end
      end
      i_valid = 1'b0;
      n_vec++; if (o_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b want 1", o_overflow); end
      n_vec++; if (o_drop_cnt !== exp_cnt(1)) begin n_err++; $display("FAIL ovf_drop_cnt: got %0d want %0d", o_drop_cnt, exp_cnt(1)); end
      n_vec++; if (o_rx_cnt !== exp_cnt(5)) begin n_err++; $display("FAIL ovf_rx_cnt: got %0d want %0d", o_rx_cnt, exp_cnt(5)); end
      n_vec++; if ({o_valid, o_data} !== {1'b1, rsp[0]}) begin n_err++;
         $display("FAIL ovf_held: got v=%b d=%h want v=1 d=%h", o_valid, o_data, rsp[0]); end
      // Push into the full FIFO on the same edge as a pop: must not drop.
      i_data  = req[6];
      i_valid = 1'b1;
      i_ready = 1'b1;
      tick;
      i_valid = 1'b0;
      n_vec++; if (o_drop_cnt !== exp_cnt(1)) begin n_err++; $display("FAIL ovf_simul_drop: got %0d want %0d", o_drop_cnt, exp_cnt(1)); end
      n_vec++; if (o_rx_cnt !== exp_cnt(6)) begin n_err++; $display("FAIL ovf_simul_rx: got %0d want %0d", o_rx_cnt, exp_cnt(6)); end
      n_vec++; if ({o_valid, o_data} !== {1'b1, rsp[1]}) begin n_err++;
         $display("FAIL ovf_drain_1: got v=%b d=%h want v=1 d=%h", o_valid, o_data, rsp[1]); end
      for (int k = 2; k < 7; k++) begin
         if (k == 5) continue;
         tick;
         n_vec++; if ({o_valid, o_data} !== {1'b1, rsp[k]}) begin n_err++;
            $display("FAIL ovf_drain_%0d: got v=%b d=%h want v=1 d=%h", k, o_valid, o_data, rsp[k]); end
      end
      tick;
      n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL ovf_empty: got o_valid %b want 0", o_valid); end
      n_vec++; if (o_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", o_overflow); end
      n_vec++; if (o_tx_cnt !== exp_cnt(6)) begin n_err++; $display("FAIL ovf_tx_cnt: got %0d want %0d", o_tx_cnt, exp_cnt(6)); end
   endtask

   task automatic test_misroute;
      logic         seen;
      logic [W-1:0] exp;
      do_reset;
      exp     = pkt(4, 4, 1, 2, 32'h00000000);
      i_ready = 1'b1;
      i_data  = pkt(2, 2, 1, 1, 32'hDEADBEEF);
      i_valid = 1'b1;
      tick;
      i_valid = 1'b0;
      seen    = 1'b0;
      repeat (4) begin
         tick;
         if (o_valid === 1'b1) seen = 1'b1;
      end
      n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL mis_no_resp: got pulse %b want 0", seen); end
      n_vec++; if (o_drop_cnt !== exp_cnt(1)) begin n_err++; $display("FAIL mis_drop_cnt: got %0d want %0d", o_drop_cnt, exp_cnt(1)); end
      n_vec++; if (o_overflow !== 1'b0) begin n_err++; $display("FAIL mis_overflow: got %b want 0", o_overflow); end
      i_data  = pkt(1, 2, 4, 4, 32'hFFFFFFFF);
      i_valid = 1'b1;
      tick;
      i_valid = 1'b0;
      tick;
      n_vec++; if ({o_valid, o_data} !== {1'b1, exp}) begin n_err++;
         $display("FAIL mis_next: got v=%b d=%h want v=1 d=%h", o_valid, o_data, exp); end
   endtask

   task automatic test_back_to_back;
      logic [W-1:0] rd, re, rf;
      do_reset;
      rd = pkt(2, 2, 1, 2, 32'hFFFFFFFF);
      re = pkt(3, 3, 1, 2, 32'h00000000);
      rf = pkt(15, 15, 1, 2, 32'h7FFFFFFE);
      i_ready = 1'b1;
      i_valid = 1'b1;
      i_data  = pkt(1, 2, 2, 2, 32'h00000000);  tick;
      i_data  = pkt(1, 2, 3, 3, 32'hFFFFFFFF);  tick;
      n_vec++; if ({o_valid, o_data} !== {1'b1, rd}) begin n_err++;
         $display("FAIL b2b_first: got v=%b d=%h want v=1 d=%h", o_valid, o_data, rd); end
      i_data  = pkt(1, 2, 15, 15, 32'h80000001); tick;
      i_valid = 1'b0;
      n_vec++; if ({o_valid, o_data} !== {1'b1, re}) begin n_err++;
         $display("FAIL b2b_second: got v=%b d=%h want v=1 d=%h", o_valid, o_data, re); end
      tick;
      n_vec++; if ({o_valid, o_data} !== {1'b1, rf}) begin n_err++;
         $display("FAIL b2b_third: got v=%b d=%h want v=1 d=%h", o_valid, o_data, rf); end
      tick;
      n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL b2b_done: got o_valid %b want 0", o_valid); end
   endtask

   task automatic test_mid_reset;
      logic seen;
      do_reset;
      i_ready = 1'b0;
      i_valid = 1'b1;
      i_data  = pkt(1, 2, 6, 6, 32'h0F0F0F0F); tick;
      i_data  = pkt(1, 2, 7, 7, 32'h33333333); tick;
      i_valid = 1'b0;
      n_vec++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL mrst_pre: got o_valid %b want 1", o_valid); end
      rst = 1'b0;
      #1;
      n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL mrst_valid: got %b want 0", o_valid); end
      n_vec++; if (o_data !== '0) begin n_err++; $display("FAIL mrst_data: got %h want 0", o_data); end
      n_vec++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL mrst_ready: got %b want 1", o_ready); end
      repeat (2) tick;
      rst     = 1'b1;
      i_ready = 1'b1;
      seen    = 1'b0;
      repeat (8) begin
         tick;
         if (o_valid === 1'b1) seen = 1'b1;
      end
      n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL mrst_stale: got pulse %b want 0", seen); end
      n_vec++; if ({o_rx_cnt, o_tx_cnt, o_drop_cnt} !== 48'd0) begin n_err++;
         $display("FAIL mrst_counters: got %h %h %h want 0", o_rx_cnt, o_tx_cnt, o_drop_cnt); end
   endtask

   initial begin
      rst     = 1'b1;
      i_valid = 1'b0;
      i_ready = 1'b0;
      i_data  = '0;
      #2;
      do_reset;
      test_reset;
      test_single;
      test_backpressure;
      test_overflow;
      test_misroute;
      test_back_to_back;
      test_mid_reset;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
